// File: rtl/soc_store_buffer.sv
// soc_store_buffer: in-order store FIFO between the M stage and the data bus.
// Define STORE_MISALIGN_CHECK_EN to reject misaligned half/full-width stores instead of aligning them.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module soc_store_buffer #(
   parameter int XLEN  = `XLEN_64b,
   parameter int DEPTH = 4,
   localparam int W    = 1 << (XLEN + 4),
   localparam int NB   = W / 8,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clk_en,
   input  logic          i_sw_m,
   input  logic          i_store_byte_m,
   input  logic          i_store_half_m,
   input  logic [W-1:0]  i_mem_addr_m,
   input  logic [W-1:0]  i_mem_data_m,
   output logic          o_stall,
   output logic          o_bus_valid,
   output logic [W-1:0]  o_bus_addr,
   output logic [W-1:0]  o_bus_data,
   output logic [NB-1:0] o_bus_be,
   input  logic          i_bus_ready,
   output logic          o_empty,
   output logic [CW-1:0] o_count,
   output logic          o_misaligned
);

   localparam int OFFW = $clog2(NB);
   localparam int PW   = $clog2(DEPTH);

   logic [W-1:0]    addr_q [DEPTH];
   logic [W-1:0]    data_q [DEPTH];
   logic [NB-1:0]   be_q   [DEPTH];
   logic [PW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [OFFW-1:0] off, off_eff;
   logic [W-1:0]    addr_new, data_new;
   logic [NB-1:0]   be_new;
   logic            full, mis, push, pop;

   assign off  = i_mem_addr_m[OFFW-1:0];
   assign full = (count_q == CW'(DEPTH));

`ifdef STORE_MISALIGN_CHECK_EN
   logic mis_q;

   assign mis     = i_sw_m & ~i_store_byte_m &
                    (i_store_half_m ? off[0] : (off != '0));
   assign off_eff = off;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis & i_clk_en;
      end
   end

   assign o_misaligned = mis_q;
`else
   assign mis = 1'b0;

   // Without the check, misaligned halves/words are silently aligned down.
   always_comb begin
      off_eff = off;
      if (!i_store_byte_m) begin
         if (i_store_half_m) off_eff[0] = 1'b0;
         else                off_eff    = '0;
      end
   end

   assign o_misaligned = 1'b0;
`endif

   // A misaligned store is dropped, so it never needs to hold the pipeline.
   assign o_stall = i_sw_m & full & ~i_bus_ready & ~mis;
   assign push    = i_sw_m & i_clk_en & ~o_stall & ~mis;
   assign pop     = o_bus_valid & i_bus_ready;
   assign count_d = count_q + CW'(push) - CW'(pop);

   always_comb begin
      addr_new = {i_mem_addr_m[W-1:OFFW], {OFFW{1'b0}}};
      if (i_store_byte_m) begin
         be_new   = NB'(1) << off_eff;
         data_new = {NB{i_mem_data_m[7:0]}};
      end else if (i_store_half_m) begin
         be_new   = NB'(2'b11) << off_eff;
         data_new = {(NB/2){i_mem_data_m[15:0]}};
      end else begin
         be_new   = '1;
         data_new = i_mem_data_m;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         if (push) begin
            addr_q[wptr_q] <= addr_new;
            data_q[wptr_q] <= data_new;
            be_q[wptr_q]   <= be_new;
            wptr_q         <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   assign o_bus_valid = (count_q != '0);
   assign o_empty     = (count_q == '0);
   assign o_count     = count_q;
   assign o_bus_addr  = addr_q[rptr_q];
   assign o_bus_data  = data_q[rptr_q];
   assign o_bus_be    = be_q[rptr_q];

endmodule

// File: tb/tb_soc_store_buffer.sv
// Bench for soc_store_buffer: directed scenarios plus a randomized run against a queue-based store model.
module tb_soc_store_buffer;

   localparam int W     = 64;
   localparam int NB    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n, clk_en, sw, sb, sh, ready;
   logic [W-1:0]  addr, data;
   logic          o_stall, o_bus_valid, o_empty, o_misaligned;
   logic [W-1:0]  o_bus_addr, o_bus_data;
   logic [NB-1:0] o_bus_be;
   logic [CW-1:0] o_count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  d;
      logic [NB-1:0] be;
   } ent_t;

   soc_store_buffer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
      .i_sw_m(sw), .i_store_byte_m(sb), .i_store_half_m(sh),
      .i_mem_addr_m(addr), .i_mem_data_m(data),
      .o_stall(o_stall), .o_bus_valid(o_bus_valid), .o_bus_addr(o_bus_addr),
      .o_bus_data(o_bus_data), .o_bus_be(o_bus_be), .i_bus_ready(ready),
      .o_empty(o_empty), .o_count(o_count), .o_misaligned(o_misaligned)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   function automatic logic [W-1:0] rep(input logic [W-1:0] v, input int bytes);
      logic [W-1:0] mask, r;
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      r = '0;
      for (int i = 0; i < NB / bytes; i++) r = r | ((v & mask) << (8 * bytes * i));
      return r;
   endfunction

   function automatic logic is_mis(input logic b, input logic h, input logic [W-1:0] a);
`ifdef STORE_MISALIGN_CHECK_EN
      if (b) return 1'b0;
      if (h) return (a % 2) != 0;
      return (a % NB) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic ent_t model(input logic b, input logic h,
                                  input logic [W-1:0] a, input logic [W-1:0] d);
      ent_t e;
      int off;
      off = int'(a % NB);
      e.a = a - W'(off);
      if (b) begin
         e.be = NB'(1 << off);
         e.d  = rep(d, 1);
      end else if (h) begin
         off  = off - (off % 2);
         e.be = NB'(3 << off);
         e.d  = rep(d, 2);
      end else begin
         e.be = '1;
         e.d  = d;
      end
      return e;
   endfunction

   task automatic idle_inputs();
      clk_en = 1'b1; sw = 1'b0; sb = 1'b0; sh = 1'b0;
      addr = '0; data = '0; ready = 1'b0;
   endtask

   task automatic drive(input logic s, input logic b, input logic h,
                        input logic [W-1:0] a, input logic [W-1:0] d);
      sw = s; sb = b; sh = h; addr = a; data = d;
   endtask

   // Leaves the bench at a falling edge with reset released and inputs idle.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      sw = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (o_bus_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", o_bus_valid); end
      n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_count); end
      n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      n_cmp++; if (o_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_mis got=%b exp=0", o_misaligned); end
      sw = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_byte();
      do_reset();
      ready = 1'b1;
      drive(1, 1, 0, 64'h1003, 64'hAB);
      #1;
      n_cmp++; if (o_bus_valid !== 1'b0) begin n_err++; $display("FAIL sb_no_bypass got=%b exp=0", o_bus_valid); end
      @(negedge clk);
      sw = 1'b0;
      #1;
      n_cmp++; if (o_bus_valid !== 1'b1) begin n_err++; $display("FAIL sb_valid got=%b exp=1", o_bus_valid); end
      n_cmp++; if (o_bus_addr !== 64'h1000) begin n_err++; $display("FAIL sb_addr got=%h exp=1000", o_bus_addr); end
      n_cmp++; if (o_bus_be !== 8'h08) begin n_err++; $display("FAIL sb_be got=%h exp=08", o_bus_be); end
      n_cmp++; if (o_bus_data !== 64'hABABABABABABABAB) begin n_err++; $display("FAIL sb_data got=%h exp=abababababababab", o_bus_data); end
      @(negedge clk);
      #1;
      n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL sb_drained got=%b exp=1", o_empty); end
   endtask

   task automatic test_half();
      do_reset();
      ready = 1'b1;
      drive(1, 0, 1, 64'h2006, 64'h1234);
      @(negedge clk);
      sw = 1'b0;
      #1;
      n_cmp++; if (o_bus_addr !== 64'h2000) begin n_err++; $display("FAIL sh_addr got=%h exp=2000", o_bus_addr); end
      n_cmp++; if (o_bus_be !== 8'hC0) begin n_err++; $display("FAIL sh_be got=%h exp=c0", o_bus_be); end
      n_cmp++; if (o_bus_data !== 64'h1234123412341234) begin n_err++; $display("FAIL sh_data got=%h exp=1234123412341234", o_bus_data); end
      @(negedge clk);
   endtask

   task automatic test_fill();
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 64'h100 + 64'(8 * i), 64'(i + 1));
         #1;
         n_cmp++; if (o_stall !== (i == 4)) begin n_err++; $display("FAIL fill_stall i=%0d got=%b exp=%b", i, o_stall, (i == 4)); end
         if (i < 4) @(negedge clk);
      end
      n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", o_count); end
      ready = 1'b1;
      #1;
      n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL fill_unstall got=%b exp=0", o_stall); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (o_bus_addr !== 64'h100 + 64'(8 * k) || o_bus_data !== 64'(k + 1)) begin
            n_err++; $display("FAIL fill_order k=%0d got=%h/%h exp=%h/%h", k, o_bus_addr, o_bus_data, 64'h100 + 64'(8 * k), 64'(k + 1));
         end
         @(negedge clk);
         sw = 1'b0;
         #1;
      end
      n_cmp++; if (o_count !== 3'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL fill_empty got=%0d/%b exp=0/1", o_count, o_empty); end
   endtask

   task automatic test_full_swap();
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 64'h300 + 64'(8 * i), 64'hA0 + 64'(i));
         @(negedge clk);
      end
      ready = 1'b1;
      drive(1, 0, 0, 64'h500, 64'h55);
      #1;
      n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL swap_stall got=%b exp=0", o_stall); end
      @(negedge clk);
      sw = 1'b0; ready = 1'b0;
      #1;
      n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL swap_count got=%0d exp=4", o_count); end
      n_cmp++; if (o_bus_addr !== 64'h308) begin n_err++; $display("FAIL swap_head got=%h exp=308", o_bus_addr); end
      ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (o_bus_addr !== 64'h500 || o_bus_data !== 64'h55) begin n_err++; $display("FAIL swap_tail got=%h/%h exp=500/55", o_bus_addr, o_bus_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 64'h700 + 64'(8 * i), 64'h77);
         @(negedge clk);
      end
      sw = 1'b0;
      #1;
      n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL rmid_pre got=%0d exp=3", o_count); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (o_bus_valid !== 1'b0 || o_count !== 3'd0 || o_empty !== 1'b1) begin
         n_err++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/1", o_bus_valid, o_count, o_empty);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         n_cmp++; if (o_bus_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got=%b exp=0", o_bus_valid); end
      end
   endtask

   task automatic test_misalign();
      do_reset();
      ready = 1'b0;
      drive(1, 0, 1, 64'h2001, 64'h1234);
      #1;
      n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall got=%b exp=0", o_stall); end
      @(negedge clk);
      sw = 1'b0;
      #1;
`ifdef STORE_MISALIGN_CHECK_EN
      n_cmp++; if (o_misaligned !== 1'b1) begin n_err++; $display("FAIL mis_pulse got=%b exp=1", o_misaligned); end
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mis_count got=%0d exp=0", o_count); end
      @(negedge clk);
      #1;
      n_cmp++; if (o_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end got=%b exp=0", o_misaligned); end
`else
      n_cmp++; if (o_bus_be !== 8'h03) begin n_err++; $display("FAIL mis_be got=%h exp=03", o_bus_be); end
      n_cmp++; if (o_bus_addr !== 64'h2000) begin n_err++; $display("FAIL mis_addr got=%h exp=2000", o_bus_addr); end
      n_cmp++; if (o_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_tied got=%b exp=0", o_misaligned); end
`endif
   endtask

   task automatic test_random();
      ent_t q[$];
      ent_t e;
      logic exp_mis, exp_stall, full, m, do_push, do_pop;
      do_reset();
      exp_mis = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         clk_en = ($urandom % 5) != 0;
         sw     = ($urandom % 3) != 0;
         sb     = ($urandom % 3) == 0;
         sh     = ($urandom % 2) == 0;
         addr   = {32'($urandom), 32'($urandom)};
         data   = {32'($urandom), 32'($urandom)};
         ready  = ((cyc / 100) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         #1;
         full      = (q.size() == DEPTH);
         m         = sw && is_mis(sb, sh, addr);
         exp_stall = sw && full && !ready && !m;
         n_cmp++; if (o_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, o_stall, exp_stall); end
         n_cmp++; if (o_count !== CW'(q.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, o_count, q.size()); end
         n_cmp++; if (o_bus_valid !== (q.size() != 0) || o_empty !== (q.size() == 0)) begin
            n_err++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", cyc, o_bus_valid, o_empty, q.size() != 0);
         end
         n_cmp++; if (o_misaligned !== exp_mis) begin n_err++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", cyc, o_misaligned, exp_mis); end
         if (q.size() != 0) begin
            n_cmp++; if (o_bus_addr !== q[0].a || o_bus_data !== q[0].d || o_bus_be !== q[0].be) begin
               n_err++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, o_bus_addr, o_bus_data, o_bus_be, q[0].a, q[0].d, q[0].be);
            end
         end
         do_pop  = (q.size() != 0) && ready;
         do_push = sw && clk_en && !exp_stall && !m;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e = model(sb, sh, addr, data);
            q.push_back(e);
         end
         exp_mis = m && clk_en;
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_byte();
      test_half();
      test_fill();
      test_full_swap();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
